// File: rtl/song_stream_sequencer_if.sv
// Sequencer-side bundle: track select/play inputs, song ROM read port,
// decoder-feeder stream and flush handshake.
interface song_stream_sequencer_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic [2:0]        current;
    logic              play;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              flush;
    logic              flush_done;
    logic              auto_next;
    logic              busy;

    modport master (
        input  current, play, rom_data, out_ready, flush_done,
        output rom_rd, rom_addr, out_data, out_valid, flush, auto_next, busy
    );

    modport slave (
        output current, play, rom_data, out_ready, flush_done,
        input  rom_rd, rom_addr, out_data, out_valid, flush, auto_next, busy
    );
endinterface

// File: rtl/song_stream_sequencer.sv
// Streams the selected track's body from the song ROM to the decoder feeder,
// flushing the decoder on every track change and pulsing auto_next at track end.
module song_stream_sequencer #(
    parameter int SONG_NUM  = 5,
    parameter int SLOT_LOG2 = 12,
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    song_stream_sequencer_if.master bus
);

    if (ADDR_W < 3 + SLOT_LOG2) begin : g_addr_check
        $error("song_stream_sequencer: ADDR_W cannot hold 3 + SLOT_LOG2 bits");
    end
    if (SONG_NUM < 1 || SONG_NUM > 8) begin : g_song_check
        $error("song_stream_sequencer: SONG_NUM must be 1..8");
    end

    localparam int MAX_LEN = (1 << SLOT_LOG2) - 1;

    typedef enum logic [3:0] {
        ST_START, ST_FLUSH, ST_WAITF, ST_HDR, ST_HLAT,
        ST_RD, ST_LAT, ST_WAIT, ST_END, ST_HOLD
    } state_t;

    state_t               state;
    logic [2:0]           track_q;
    logic [SLOT_LOG2-1:0] idx;
    logic [SLOT_LOG2-1:0] len;

    logic                 change;
    logic                 handshake;
    logic [ADDR_W-1:0]    base;
    logic [SLOT_LOG2-1:0] idx_inc;
    logic [ADDR_W-1:0]    body_addr_cur;
    logic [ADDR_W-1:0]    body_addr_next;
    logic [31:0]          data_ext;
    logic [SLOT_LOG2-1:0] hdr_len;

    // Word 0 of each slot is the body length; body words follow at offset 1.
    assign change         = (bus.current != track_q);
    assign handshake      = bus.out_valid & bus.out_ready;
    assign base           = ADDR_W'({track_q, {SLOT_LOG2{1'b0}}});
    assign idx_inc        = idx + 1'b1;
    assign body_addr_cur  = base + ADDR_W'(idx) + ADDR_W'(1);
    assign body_addr_next = base + ADDR_W'(idx_inc) + ADDR_W'(1);
    assign data_ext       = 32'(bus.rom_data);
    assign hdr_len        = (data_ext > 32'(MAX_LEN)) ? SLOT_LOG2'(MAX_LEN)
                                                      : data_ext[SLOT_LOG2-1:0];

    // Outputs are registered alongside the state they belong to; rom_rd is
    // raised on entry to the reading state so the data lands one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_START;
            track_q       <= '0;
            idx           <= '0;
            len           <= '0;
            bus.rom_rd    <= 1'b0;
            bus.rom_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.flush     <= 1'b0;
            bus.auto_next <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.rom_rd    <= 1'b0;
            bus.auto_next <= 1'b0;
            if (change && state != ST_START && state != ST_FLUSH) begin
                state         <= ST_FLUSH;
                bus.out_valid <= 1'b0;
                bus.flush     <= 1'b1;
                bus.busy      <= 1'b1;
            end else begin
                case (state)
                    ST_START: begin
                        state     <= ST_FLUSH;
                        bus.flush <= 1'b1;
                        bus.busy  <= 1'b1;
                    end
                    ST_FLUSH: begin
                        track_q       <= bus.current;
                        bus.out_valid <= 1'b0;
                        idx           <= '0;
                        state         <= ST_WAITF;
                    end
                    ST_WAITF: begin
                        if (bus.flush_done) begin
                            bus.flush    <= 1'b0;
                            bus.rom_rd   <= 1'b1;
                            bus.rom_addr <= base;
                            state        <= ST_HDR;
                        end
                    end
                    ST_HDR: state <= ST_HLAT;
                    ST_HLAT: begin
                        len <= hdr_len;
                        if (hdr_len == '0) begin
                            bus.auto_next <= 1'b1;
                            state         <= ST_END;
                        end else begin
                            bus.rom_rd   <= bus.play;
                            bus.rom_addr <= body_addr_cur;
                            state        <= ST_RD;
                        end
                    end
                    // A paused RD keeps rom_rd low; a read issued here moves on.
                    ST_RD: begin
                        if (bus.rom_rd) begin
                            state <= ST_LAT;
                        end else if (bus.play) begin
                            bus.rom_rd   <= 1'b1;
                            bus.rom_addr <= body_addr_cur;
                        end
                    end
                    ST_LAT: begin
                        bus.out_data  <= bus.rom_data;
                        bus.out_valid <= 1'b1;
                        state         <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (handshake) begin
                            bus.out_valid <= 1'b0;
                            idx           <= idx_inc;
                            if (idx_inc == len) begin
                                bus.auto_next <= 1'b1;
                                state         <= ST_END;
                            end else begin
                                bus.rom_rd   <= bus.play;
                                bus.rom_addr <= body_addr_next;
                                state        <= ST_RD;
                            end
                        end
                    end
                    ST_END: begin
                        bus.busy <= 1'b0;
                        state    <= ST_HOLD;
                    end
                    ST_HOLD: state <= ST_HOLD;
                    default: state <= ST_START;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_stream_sequencer.sv
// Bench for song_stream_sequencer: ROM and decoder-flush models plus a
// scoreboard of expected ROM reads and accepted stream words.
module tb_song_stream_sequencer;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 16;
    localparam int SLOT_LOG2 = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    song_stream_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    song_stream_sequencer #(
        .SONG_NUM(5), .SLOT_LOG2(SLOT_LOG2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0]       hdr [8];
    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] exp_word [$];
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_word;
    logic [ADDR_W-1:0] last_rd;
    int an_count, flush_cycles, valid_cycles, rd_count;
    int fcnt = 0;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        if (a[SLOT_LOG2-1:0] == '0) return hdr[a[ADDR_W-1:SLOT_LOG2]];
        return DATA_W'(a) ^ 16'h5A3C;
    endfunction

    // Synchronous ROM: data appears the cycle after the read strobe.
    always @(posedge clk) if (bus.rom_rd) bus.rom_data <= rom_word(bus.rom_addr);

    // Decoder acknowledges on the third cycle of a flush request.
    always @(posedge clk) begin
        #2;
        if (bus.flush) begin
            bus.flush_done = (fcnt == 2);
            fcnt++;
        end else begin
            bus.flush_done = 1'b0;
            fcnt = 0;
        end
    end

    // Scoreboard: every ROM read and every accepted word pops its expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rom_rd) begin
                rd_count++;
                last_rd = bus.rom_addr;
                checks++;
                if (exp_addr.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rom_read got=%h exp=none", bus.rom_addr);
                end else begin
                    e_addr = exp_addr.pop_front();
                    if (bus.rom_addr !== e_addr) begin
                        failures++;
                        $display("[TB] FAIL rom_addr got=%h exp=%h", bus.rom_addr, e_addr);
                    end
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_word.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL out_word got=%h exp=none", bus.out_data);
                end else begin
                    e_word = exp_word.pop_front();
                    if (bus.out_data !== e_word) begin
                        failures++;
                        $display("[TB] FAIL out_data got=%h exp=%h", bus.out_data, e_word);
                    end
                end
            end
            if (bus.out_valid) valid_cycles++;
            if (bus.auto_next) an_count++;
            if (bus.flush)     flush_cycles++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_sb;
        exp_addr.delete();
        exp_word.delete();
        an_count     = 0;
        flush_cycles = 0;
        valid_cycles = 0;
        rd_count     = 0;
    endtask

    task automatic push_track(input logic [2:0] t, input int len);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'({t, 12'h000});
        exp_addr.push_back(a);
        for (int i = 1; i <= len; i++) begin
            exp_addr.push_back(a + ADDR_W'(i));
            exp_word.push_back(rom_word(a + ADDR_W'(i)));
        end
    endtask

    task automatic run_until_idle(input int limit, output bit ok);
        bit seen;
        seen = 1'b0;
        ok   = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step(1);
            if (bus.busy) seen = 1'b1;
            else if (seen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step(1);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.current   = 3'd0;
        bus.play      = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) hdr[i] = 16'd0;
        hdr[0] = 16'd3;
        step(3);
        checks++;
        if ({bus.rom_rd, bus.out_valid, bus.flush, bus.auto_next, bus.busy} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%b exp=00000",
                     {bus.rom_rd, bus.out_valid, bus.flush, bus.auto_next, bus.busy});
        end
        checks++;
        if (bus.rom_addr !== '0) begin
            failures++;
            $display("[TB] FAIL reset_addr got=%h exp=0", bus.rom_addr);
        end
        checks++;
        if (bus.out_data !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h exp=0", bus.out_data);
        end
    endtask

    task automatic test_basic;
        bit ok;
        clear_sb();
        push_track(3'd0, 3);
        rst = 1'b0;
        run_until_idle(300, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL basic_timeout got=busy exp=idle"); end
        checks++;
        if (exp_addr.size() != 0 || exp_word.size() != 0) begin
            failures++;
            $display("[TB] FAIL basic_left got=%0d/%0d exp=0/0", exp_addr.size(), exp_word.size());
        end
        checks++;
        if (an_count != 1) begin failures++; $display("[TB] FAIL basic_auto_next got=%0d exp=1", an_count); end
        checks++;
        if (flush_cycles != 3) begin
            failures++;
            $display("[TB] FAIL basic_flush_len got=%0d exp=3", flush_cycles);
        end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_zero_len;
        bit ok;
        clear_sb();
        hdr[2] = 16'd0;
        exp_addr.push_back(15'h2000);
        bus.current = 3'd2;
        run_until_idle(300, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL zero_timeout got=busy exp=idle"); end
        checks++;
        if (rd_count != 1) begin failures++; $display("[TB] FAIL zero_reads got=%0d exp=1", rd_count); end
        checks++;
        if (an_count != 1) begin failures++; $display("[TB] FAIL zero_auto_next got=%0d exp=1", an_count); end
        checks++;
        if (valid_cycles != 0) begin failures++; $display("[TB] FAIL zero_valid got=%0d exp=0", valid_cycles); end
    endtask

    task automatic test_change_midstream;
        bit ok;
        clear_sb();
        hdr[1] = 16'd8;
        hdr[4] = 16'd2;
        bus.out_ready = 1'b0;
        exp_addr.push_back(15'h1000);
        exp_addr.push_back(15'h1001);
        bus.current = 3'd1;
        wait_valid(300, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL chg_valid_timeout got=0 exp=1"); end
        bus.current = 3'd4;
        step(1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.flush !== 1'b1) begin
            failures++;
            $display("[TB] FAIL chg_drop got=valid%b/flush%b exp=valid0/flush1", bus.out_valid, bus.flush);
        end
        bus.out_ready = 1'b1;
        push_track(3'd4, 2);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (exp_addr.size() == 2) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || an_count != 0) begin
            failures++;
            $display("[TB] FAIL chg_hdr got=ok%0d/an%0d exp=ok1/an0", ok, an_count);
        end
        run_until_idle(300, ok);
        checks++;
        if (!ok || an_count != 1 || exp_addr.size() != 0 || exp_word.size() != 0) begin
            failures++;
            $display("[TB] FAIL chg_end got=ok%0d/an%0d/left%0d exp=ok1/an1/left0",
                     ok, an_count, exp_addr.size() + exp_word.size());
        end
    endtask

    task automatic test_clamp;
        bit ok;
        clear_sb();
        hdr[1] = 16'hFFFF;
        bus.out_ready = 1'b1;
        bus.play      = 1'b1;
        push_track(3'd1, 4095);
        bus.current = 3'd1;
        run_until_idle(15000, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL clamp_timeout got=busy exp=idle"); end
        checks++;
        if (last_rd !== 15'h1FFF) begin failures++; $display("[TB] FAIL clamp_last got=%h exp=1fff", last_rd); end
        checks++;
        if (rd_count != 4096 || exp_word.size() != 0) begin
            failures++;
            $display("[TB] FAIL clamp_count got=%0d/%0d exp=4096/0", rd_count, exp_word.size());
        end
        checks++;
        if (an_count != 1) begin failures++; $display("[TB] FAIL clamp_auto_next got=%0d exp=1", an_count); end
    endtask

    task automatic test_play_pause;
        bit ok;
        int n;
        clear_sb();
        hdr[3] = 16'd4;
        bus.out_ready = 1'b0;
        bus.play      = 1'b1;
        push_track(3'd3, 4);
        bus.current = 3'd3;
        wait_valid(300, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL pause_valid_timeout got=0 exp=1"); end
        bus.play      = 1'b0;
        bus.out_ready = 1'b1;
        step(1);
        n = rd_count;
        step(10);
        checks++;
        if (rd_count != n || n != 2) begin
            failures++;
            $display("[TB] FAIL pause_reads got=%0d->%0d exp=2->2", n, rd_count);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pause_state got=valid%b/busy%b exp=valid0/busy1", bus.out_valid, bus.busy);
        end
        bus.play = 1'b1;
        step(1);
        checks++;
        if (bus.rom_rd !== 1'b1 || bus.rom_addr !== 15'h3002) begin
            failures++;
            $display("[TB] FAIL pause_resume got=rd%b@%h exp=rd1@3002", bus.rom_rd, bus.rom_addr);
        end
        run_until_idle(300, ok);
        checks++;
        if (!ok || an_count != 1 || exp_addr.size() != 0 || exp_word.size() != 0) begin
            failures++;
            $display("[TB] FAIL pause_end got=ok%0d/an%0d/left%0d exp=ok1/an1/left0",
                     ok, an_count, exp_addr.size() + exp_word.size());
        end
    endtask

    task automatic test_stall_reset;
        bit ok;
        logic [DATA_W-1:0] held;
        clear_sb();
        hdr[0] = 16'd3;
        bus.out_ready = 1'b0;
        exp_addr.push_back(15'h0000);
        exp_addr.push_back(15'h0001);
        held = rom_word(15'h0001);
        bus.current = 3'd0;
        wait_valid(300, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL stall_valid_timeout got=0 exp=1"); end
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
                failures++;
                $display("[TB] FAIL stall_hold[%0d] got=%b/%h exp=1/%h", i, bus.out_valid, bus.out_data, held);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.rom_rd, bus.out_valid, bus.flush, bus.auto_next, bus.busy} !== 5'b0
            || bus.out_data !== '0 || bus.rom_addr !== '0) begin
            failures++;
            $display("[TB] FAIL stall_reset got=%b/%h/%h exp=00000/0/0",
                     {bus.rom_rd, bus.out_valid, bus.flush, bus.auto_next, bus.busy},
                     bus.out_data, bus.rom_addr);
        end
        step(2);
        clear_sb();
        push_track(3'd0, 3);
        bus.out_ready = 1'b1;
        rst = 1'b0;
        run_until_idle(300, ok);
        checks++;
        if (!ok || an_count != 1 || exp_addr.size() != 0 || exp_word.size() != 0) begin
            failures++;
            $display("[TB] FAIL restart got=ok%0d/an%0d/left%0d exp=ok1/an1/left0",
                     ok, an_count, exp_addr.size() + exp_word.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_change_midstream();
        test_clamp();
        test_play_pause();
        test_stall_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
